// File: rtl/piece_drop_if.sv
// Control/status bundle between a game front end (master) and piece_drop_ctrl (slave).
interface piece_drop_if;
    logic       start;
    logic       move_left;
    logic       move_right;
    logic       drop;
    logic [3:0] x_pos;
    logic [4:0] y_pos;
    logic       piece_active;
    logic       lock_pulse;
    logic [7:0] score;
    logic       game_over;

    modport master (
        output start, move_left, move_right, drop,
        input  x_pos, y_pos, piece_active, lock_pulse, score, game_over
    );

    modport slave (
        input  start, move_left, move_right, drop,
        output x_pos, y_pos, piece_active, lock_pulse, score, game_over
    );
endinterface

// File: rtl/piece_drop_ctrl.sv
// Falling-piece controller: gravity, lateral moves, per-column stacking, score and game over.
// Optional hard drop is compiled in when HARD_DROP_EN is defined.
module piece_drop_ctrl #(
    parameter int COLS     = 10,
    parameter int ROWS     = 20,
    parameter int START_X  = 5,
    parameter int TICK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    piece_drop_if.slave bus
);

    localparam int             DW        = $clog2(TICK_DIV);
    localparam logic [DW-1:0]  TICK_LAST = DW'(TICK_DIV - 1);
    localparam logic [DW-1:0]  DIV_ZERO  = DW'(0);
    localparam logic [DW-1:0]  DIV_ONE   = DW'(1);
    localparam logic [5:0]     ROWS_M1   = 6'(ROWS - 1);
    localparam logic [4:0]     ROWS_H    = 5'(ROWS);
    localparam logic [3:0]     X_START   = 4'(START_X);
    localparam logic [3:0]     X_LAST    = 4'(COLS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SPAWN    = 3'd1,
        ST_FALL     = 3'd2,
        ST_LOCK     = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [3:0]      x_r, x_s;
    logic [4:0]      y_r, y_s;
    logic [DW-1:0]   div_r, div_s;
    logic [7:0]      score_r, score_s;
    logic [4:0]      h_r [COLS];
    logic [4:0]      h_s [COLS];
    logic            piece_active_r;
    logic            lock_pulse_r;
    logic            game_over_r;

    logic [4:0]      h_cur_s, h_left_s, h_right_s;
    logic [5:0]      y6_s;
    logic            landed_s, left_ok_s, right_ok_s, tick_s;
    logic            drop_req_s;
    logic [4:0]      drop_y_s;

    // Neighbour heights read as 0 at the board edges; the x bound checks gate them anyway.
    assign h_cur_s    = h_r[x_r];
    assign h_left_s   = (x_r != 4'd0)   ? h_r[x_r - 4'd1] : 5'd0;
    assign h_right_s  = (x_r != X_LAST) ? h_r[x_r + 4'd1] : 5'd0;
    assign y6_s       = {1'b0, y_r};
    assign landed_s   = (y6_s + {1'b0, h_cur_s}) >= ROWS_M1;
    assign left_ok_s  = (x_r != 4'd0)   && ((y6_s + {1'b0, h_left_s})  <= ROWS_M1);
    assign right_ok_s = (x_r != X_LAST) && ((y6_s + {1'b0, h_right_s}) <= ROWS_M1);
    assign tick_s     = (div_r == TICK_LAST);

`ifdef HARD_DROP_EN
    assign drop_req_s = bus.drop;
    assign drop_y_s   = 5'(ROWS_M1 - {1'b0, h_cur_s});
`else
    logic unused_drop_s;
    assign unused_drop_s = bus.drop;
    assign drop_req_s    = 1'b0;
    assign drop_y_s      = y_r;
`endif

    // Next-state and datapath updates for the game FSM.
    always_comb begin
        state_s = state_r;
        x_s     = x_r;
        y_s     = y_r;
        div_s   = div_r;
        score_s = score_r;
        h_s     = h_r;
        case (state_r)
            ST_IDLE, ST_GAMEOVER: begin
                if (bus.start) begin
                    for (int c = 0; c < COLS; c++) begin
                        h_s[c] = 5'd0;
                    end
                    score_s = 8'd0;
                    state_s = ST_SPAWN;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SPAWN: begin
                x_s   = X_START;
                y_s   = 5'd0;
                div_s = DIV_ZERO;
                if (h_r[X_START] == ROWS_H) begin
                    state_s = ST_GAMEOVER;
                end else begin
                    state_s = ST_FALL;
                end
            end
            ST_FALL: begin
                div_s = tick_s ? DIV_ZERO : (div_r + DIV_ONE);
                if (drop_req_s) begin
                    y_s     = drop_y_s;
                    state_s = ST_LOCK;
                end else if (tick_s) begin
                    if (landed_s) begin
                        state_s = ST_LOCK;
                    end else begin
                        y_s = y_r + 5'd1;
                    end
                end else if (bus.move_left && !bus.move_right) begin
                    if (left_ok_s) begin
                        x_s = x_r - 4'd1;
                    end else begin
                        x_s = x_r;
                    end
                end else if (bus.move_right && !bus.move_left) begin
                    if (right_ok_s) begin
                        x_s = x_r + 4'd1;
                    end else begin
                        x_s = x_r;
                    end
                end else begin
                    x_s = x_r;
                end
            end
            ST_LOCK: begin
                h_s[x_r] = h_cur_s + 5'd1;
                score_s  = (score_r == 8'd255) ? 8'd255 : (score_r + 8'd1);
                state_s  = ST_SPAWN;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status flags; flags track the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            x_r            <= X_START;
            y_r            <= 5'd0;
            div_r          <= DIV_ZERO;
            score_r        <= 8'd0;
            piece_active_r <= 1'b0;
            lock_pulse_r   <= 1'b0;
            game_over_r    <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
                h_r[c] <= 5'd0;
            end
        end else begin
            state_r        <= state_s;
            x_r            <= x_s;
            y_r            <= y_s;
            div_r          <= div_s;
            score_r        <= score_s;
            piece_active_r <= (state_s == ST_FALL);
            lock_pulse_r   <= (state_s == ST_LOCK);
            game_over_r    <= (state_s == ST_GAMEOVER);
            h_r            <= h_s;
        end
    end

    assign bus.x_pos        = x_r;
    assign bus.y_pos        = y_r;
    assign bus.piece_active = piece_active_r;
    assign bus.lock_pulse   = lock_pulse_r;
    assign bus.score        = score_r;
    assign bus.game_over    = game_over_r;

endmodule

// File: doc/piece_drop_ctrl.md
PIECE_DROP_CTRL -- requirements
Module: piece_drop_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 10, meaning number of board columns (x = 0..COLS-1).
REQ-002 SHALL have parameter ROWS, default 20, meaning number of board rows (y = 0 top .. ROWS-1 bottom).
REQ-003 SHALL have parameter START_X, default 5, meaning spawn column.
REQ-004 SHALL have parameter TICK_DIV, default 25000000, meaning clk cycles per gravity step (>= 2).
REQ-005 SHALL have port clk  input  1  system clock; all logic on rising edge; one clock domain.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  level; begins/restarts a game from IDLE or GAMEOVER.
REQ-008 SHALL have port move_left  input  1  one-cycle request to shift piece one column left.
REQ-009 SHALL have port move_right  input  1  one-cycle request to shift piece one column right.
REQ-010 SHALL have port drop  input  1  one-cycle hard-drop request (see Configuration).
REQ-011 SHALL have port x_pos  output  4  current piece column.
REQ-012 SHALL have port y_pos  output  5  current piece row.
REQ-013 SHALL have port piece_active  output  1  high while a piece is falling (state FALL).
REQ-014 SHALL have port lock_pulse  output  1  one-cycle pulse when a piece is locked.
REQ-015 SHALL have port score  output  8  count of locked pieces, saturating at 255.
REQ-016 SHALL have port game_over  output  1  high while in state GAMEOVER.

Function
REQ-017 SHALL implement FSM states IDLE, SPAWN, FALL, LOCK, GAMEOVER; all outputs registered.
REQ-018 SHALL hold per-column stack height h[c], 5 bits each, range 0..ROWS.
REQ-019 IDLE: wait; start=1 -> clear all h[c], score=0 -> SPAWN next cycle.
REQ-020 SPAWN (1 cycle): x=START_X, y=0, divider=0; if h[START_X]==ROWS -> GAMEOVER, else -> FALL.
REQ-021 FALL: divider counts 0..TICK_DIV-1 and wraps; tick is the cycle divider==TICK_DIV-1.
REQ-022 Landed condition: y + h[x] >= ROWS-1 (evaluated with 6-bit arithmetic, no wrap).
REQ-023 FALL priority per cycle: drop (if enabled) > tick > horizontal move; one action per cycle.
REQ-024 On tick: if landed -> LOCK, else y <= y+1; move requests in that cycle are discarded.
REQ-025 move_left legal iff x>0 and y + h[x-1] <= ROWS-1; then x <= x-1, else ignored.
REQ-026 move_right legal iff x<COLS-1 and y + h[x+1] <= ROWS-1; then x <= x+1, else ignored.
REQ-027 move_left and move_right both high -> both ignored.
REQ-028 LOCK (1 cycle): h[x] <= h[x]+1, score <= min(score+1,255), lock_pulse=1, piece_active=0 -> SPAWN.
REQ-029 GAMEOVER: game_over=1, x/y held; start=1 -> clear h[c], score=0 -> SPAWN.
REQ-030 start is ignored in SPAWN, FALL, LOCK.

Reset
REQ-031 rst SHALL override all other inputs in the same cycle.
REQ-032 On rst: state=IDLE, x_pos=START_X, y_pos=0, piece_active=0, lock_pulse=0, score=0, game_over=0, divider=0, all h[c]=0.
REQ-033 rst mid-FALL or mid-LOCK SHALL abandon the piece with no height or score update.

Configuration
REQ-034 Macro HARD_DROP_EN defined: drop=1 in FALL sets y <= ROWS-1-h[x] and enters LOCK next cycle, regardless of tick/moves.
REQ-035 Macro HARD_DROP_EN undefined: drop port present but ignored; no drop logic synthesized.

Verification (TICK_DIV=4, defaults otherwise)
REQ-036 rst, start pulse -> SPAWN then FALL with x=5, y=0, piece_active=1; y increments every 4 cycles.
REQ-037 Empty board, no moves -> y reaches 19, next tick -> lock_pulse one cycle, h[5]=1, score=1, new piece at y=0.
REQ-038 Piece at x=0, move_left -> x stays 0; move_left and move_right same cycle -> x unchanged; move_right at tick cycle -> ignored.
REQ-039 Lock 20 pieces in column 5 -> 20th lock then SPAWN -> game_over=1, piece_active=0; start -> score=0, piece active at x=5.
REQ-040 HARD_DROP_EN, h[3]=4, piece at x=3 y=2, drop -> y=15, next cycle lock_pulse=1, h[3]=5; without macro, drop has no effect.
REQ-041 rst asserted during FALL at y=10 -> next cycle IDLE, all outputs at reset values, score unchanged at 0.
